// File: rtl/imem_pkg.sv
// Shared sizing, word type and loader state encoding for the instruction-memory boot loader.
package imem_pkg;

    localparam int IMEM_ADDR_W = 7;
    localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CSUM,
        DONE
    } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; the first byte of a word ends up in [31:24].
module byte_packer
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       accept,
    input  logic [7:0] byte_in,
    output logic       word_ready,
    output word_t      word
);

    logic [1:0] byte_cnt_q, byte_cnt_d;
    word_t      shift_q, shift_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (clear) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[23:0], byte_in};
        end
    end

    // The completed word includes the byte accepted this cycle, so it is valid alongside word_ready.
    assign word_ready = accept && !clear && (byte_cnt_q == 2'd3);
    assign word       = {shift_q[23:0], byte_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: packs streamed bytes into words and writes them from word 0.
// Optional trailing checksum word is enabled with the IMEM_LOADER_CHECKSUM_EN macro.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    word_t             wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              accept, pack_clear, word_ready;
    word_t             packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    word_t             xor_q, xor_d;
    logic              err_q, err_d;
`endif

    assign byte_ready = (state_q == LOAD) || (state_q == CSUM);
    assign accept     = byte_valid && byte_ready && !abort;
    assign pack_clear = abort || (start && (state_q == IDLE));

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear),
        .accept     (accept),
        .byte_in    (byte_data),
        .word_ready (word_ready),
        .word       (packed_word)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        err_d      = err_q;
`endif
        // Abort outranks everything, including a start in the same cycle.
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count_d    = (num_words > DEPTH_C) ? DEPTH_C : num_words;
                        word_cnt_d = '0;
                        done_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d      = '0;
                        err_d      = 1'b0;
`endif
                        if (num_words == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (word_ready) begin
                        state_d = WRITE;
                        waddr_d = word_cnt_q[ADDR_W-1:0];
                        wdata_d = packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d   = xor_q ^ packed_word;
`endif
                    end
                end
                WRITE: begin
                    word_cnt_d = word_cnt_q + ONE_C;
                    if (word_cnt_d == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = LOAD;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (word_ready) begin
                        err_d   = (packed_word != xor_q);
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
`endif
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
            err_q      <= err_d;
`endif
        end
    end

    assign imem_we    = (state_q == WRITE);
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == LOAD) || (state_q == WRITE) || (state_q == CSUM);
    assign cpu_hold   = busy;
    assign done       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads, random loads against a word-list model,
// and hand-written abort / reset / start-while-busy / checksum sequences.
module tb_imem_loader;

    localparam int AW = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, imem_we, busy, cpu_hold, done, err;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]     stream[$];
    logic [AW+31:0] writes[$];
    int             we_len = 0;

    typedef struct {
        logic [7:0] nw;
        int         gap_max;
        int         exp_writes;
    } vec_t;

    vec_t vecs[5];

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: logs every write strobe and checks its width and companion outputs.
    always @(negedge clk) begin
        if (imem_we) begin
            writes.push_back({imem_waddr, imem_wdata});
            we_len++;
            checkOutput("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
            checkOutput("busy_in_write", {63'd0, busy}, 64'd1);
        end else if (we_len != 0) begin
            checkOutput("we_width", 64'(we_len), 64'd1);
            we_len = 0;
        end
    end

    function automatic logic [31:0] getWord(input int i);
        return {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
    endfunction

    task automatic applyStimulus(input logic [7:0] nw);
        start     = 1'b1;
        num_words = nw;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit ok;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            byte_data = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    // Sends stream[from..to-1]; after the 4th byte of each data word the write strobe must be up.
    task automatic sendRange(input int from, input int to, input int n, input int gap_max);
        for (int i = from; i < to; i++) begin
            sendByte(stream[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
            if (i < 4*n && (i % 4) == 3) begin
                checkOutput("we_latency", {63'd0, imem_we}, 64'd1);
                checkOutput("wdata_at_we", 64'(imem_wdata), 64'(getWord(i/4)));
            end
        end
    endtask

    task automatic waitDone(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
    endtask

    task automatic checkWrites(input string tag, input int n);
        checkOutput({tag, ":write_count"}, 64'(writes.size()), 64'(n));
        for (int i = 0; i < writes.size() && i < n; i++) begin
            logic [AW-1:0] a;
            a = AW'(i);
            checkOutput({tag, ":write_entry"}, 64'(writes[i]), 64'({a, getWord(i)}));
        end
    endtask

    task automatic runLoad(input string tag, input logic [7:0] nw, input int gap_max, input int exp_n);
        int  n;
        bit  found;
        bit  exp_err;
        n = (nw > DEPTH) ? DEPTH : int'(nw);
        exp_err = 1'b0;
        writes.delete();
        if (stream.size() == 0)
            for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (n > 0) begin
            logic [31:0] x;
            logic [31:0] given;
            x = '0;
            for (int i = 0; i < n; i++) x ^= getWord(i);
            if (stream.size() == 4*n) begin
                stream.push_back(x[31:24]); stream.push_back(x[23:16]);
                stream.push_back(x[15:8]);  stream.push_back(x[7:0]);
            end
            given = getWord(n);
            exp_err = (given != x);
        end
`endif
        applyStimulus(nw);
        if (n == 0) begin
            waitDone(2, found);
            checkOutput({tag, ":done_fast"}, {63'd0, found}, 64'd1);
        end else begin
            checkOutput({tag, ":busy_after_start"}, {62'd0, busy, cpu_hold}, 64'd3);
            checkOutput({tag, ":done_cleared"}, {63'd0, done}, 64'd0);
            sendRange(0, stream.size(), n, gap_max);
            waitDone(12, found);
            checkOutput({tag, ":done_seen"}, {63'd0, found}, 64'd1);
        end
        checkOutput({tag, ":idle_flags"}, {61'd0, busy, cpu_hold, byte_ready}, 64'd0);
        checkOutput({tag, ":err"}, {63'd0, err}, {63'd0, exp_err});
        @(posedge clk); #1;
        checkOutput({tag, ":done_sticky"}, {63'd0, done}, 64'd1);
        checkWrites(tag, exp_n);
        if (n > 0) begin
            checkOutput({tag, ":hold_addr"}, 64'(imem_waddr), 64'(n - 1));
            checkOutput({tag, ":hold_data"}, 64'(imem_wdata), 64'(getWord(n - 1)));
        end
        stream.delete();
    endtask

    initial begin
        bit found;

        vecs[0] = '{8'd2,   0, 2};
        vecs[1] = '{8'd1,   4, 1};
        vecs[2] = '{8'd0,   0, 0};
        vecs[3] = '{8'd200, 0, 128};
        vecs[4] = '{8'd3,   2, 3};

        #3;
        checkOutput("reset_outputs",
                    {19'd0, byte_ready, imem_we, imem_waddr, imem_wdata, busy, cpu_hold, done, err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic load");
        stream = '{8'h3C, 8'h01, 8'h10, 8'h01, 8'hAC, 8'h22, 8'h00, 8'h04};
        runLoad("basic", 8'd2, 0, 2);

        $display("[TB] gapped load");
        stream = '{8'h12, 8'h34, 8'h56, 8'h78};
        runLoad("gapped", 8'd1, 5, 1);

        $display("[TB] vector table");
        for (int v = 0; v < 5; v++) runLoad($sformatf("vec%0d", v), vecs[v].nw, vecs[v].gap_max, vecs[v].exp_writes);

        $display("[TB] random loads");
        for (int r = 0; r < 6; r++) begin
            logic [7:0] nw;
            nw = 8'($urandom_range(1, 9));
            runLoad($sformatf("rand%0d", r), nw, int'($urandom_range(0, 3)), int'(nw));
        end

        $display("[TB] abort after 6 bytes");
        writes.delete();
        for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
        applyStimulus(8'd2);
        sendRange(0, 6, 2, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort:flags", {60'd0, busy, cpu_hold, done, byte_ready}, 64'd0);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        repeat (3) @(posedge clk);
        #1 byte_valid = 1'b0;
        checkWrites("abort", 1);
        stream.delete();
        runLoad("after_abort", 8'd2, 1, 2);

        $display("[TB] reset mid-word");
        writes.delete();
        for (int i = 0; i < 12; i++) stream.push_back(8'($urandom));
        applyStimulus(8'd3);
        sendRange(0, 6, 3, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_mid:outputs",
                    {19'd0, byte_ready, imem_we, imem_waddr, imem_wdata, busy, cpu_hold, done, err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkWrites("reset_mid", 1);
        stream.delete();
        runLoad("after_reset", 8'd1, 0, 1);

        $display("[TB] start while busy");
        writes.delete();
        for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
        applyStimulus(8'd2);
        sendRange(0, 3, 2, 0);
        applyStimulus(8'd5);
        sendRange(3, 8, 2, 0);
        waitDone(12, found);
        checkOutput("busy_start:done_seen", {63'd0, found}, 64'd1);
        @(posedge clk); #1;
        checkWrites("busy_start", 2);
        stream.delete();

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum good");
        stream = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                   8'h33, 8'h33, 8'h33, 8'h33};
        runLoad("csum_good", 8'd2, 0, 2);
        $display("[TB] checksum bad");
        stream = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                   8'h00, 8'h00, 8'h00, 8'h00};
        runLoad("csum_bad", 8'd2, 0, 2);
        checkOutput("csum_bad:err_set", {63'd0, err}, 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
